dmem_mmio_bridge: RTL

// - Parametrised next-generation data memory for the processor/VGA system: dual-port RAM

---
 rtl/dmem_mmio_bridge.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dmem_mmio_bridge.sv
// dmem_mmio_bridge: dual-port data RAM (processor R/W, VGA R/O) with an MMIO window for
// synchronised input channels and a vsync frame counter. Optional macro: MMIO_STICKY_EN.
`default_nettype none

module dmem_mmio_bridge #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 12,
  parameter int                N_IN      = 4,
  parameter int                IN_W      = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 'hFF0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    proc_addr,
  input  logic [DATA_W-1:0]    proc_wdata,
  input  logic                 proc_wren,
  output logic [DATA_W-1:0]    proc_rdata,
  input  logic [ADDR_W-1:0]    vga_addr,
  output logic [DATA_W-1:0]    vga_rdata,
  input  logic [N_IN*IN_W-1:0] in_raw,
  input  logic                 vsync
);

  localparam int                CH_W       = N_IN * IN_W;
  localparam logic [ADDR_W-1:0] FRAME_ADDR = MMIO_BASE + ADDR_W'(N_IN);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  logic [DATA_W-1:0] proc_rdata_q, proc_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q;
  logic [CH_W-1:0]   in_s1_q, in_s2_q;
  logic              vs_s1_q, vs_s2_q, vs_prev_q;
  logic [DATA_W-1:0] frame_cnt_q, frame_cnt_d;

  logic              is_mmio;
  logic              frame_clr;
  logic              vs_rise;
  logic [CH_W-1:0]   chan_src;
  logic [DATA_W-1:0] mmio_rdata;

  assign is_mmio   = (proc_addr >= MMIO_BASE);
  assign frame_clr = proc_wren && (proc_addr == FRAME_ADDR);
  assign vs_rise   = vs_s2_q && !vs_prev_q;

`ifdef MMIO_STICKY_EN
  logic [CH_W-1:0] in_s3_q;
  logic [CH_W-1:0] sticky_q, sticky_d;
  logic [CH_W-1:0] rd_clr;

  // A fresh edge on the clearing cycle must survive, so OR it in after the clear.
  always_comb begin
    rd_clr = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (proc_addr == MMIO_BASE + ADDR_W'(i)) rd_clr[i*IN_W +: IN_W] = '1;
    end
    sticky_d = (sticky_q & ~rd_clr) | (in_s2_q & ~in_s3_q);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      in_s3_q  <= '0;
      sticky_q <= '0;
    end else begin
      in_s3_q  <= in_s2_q;
      sticky_q <= sticky_d;
    end
  end

  assign chan_src = sticky_q;
`else
  assign chan_src = in_s2_q;
`endif

  always_comb begin
    mmio_rdata = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (proc_addr == MMIO_BASE + ADDR_W'(i)) mmio_rdata = DATA_W'(chan_src[i*IN_W +: IN_W]);
    end
    if (proc_addr == FRAME_ADDR) mmio_rdata = frame_cnt_q;
  end

  always_comb begin
    proc_rdata_d = is_mmio ? mmio_rdata : mem[proc_addr];
    frame_cnt_d  = frame_cnt_q;
    if (frame_clr)    frame_cnt_d = '0;
    else if (vs_rise) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  // RAM is not reset; gating on reset drops writes that coincide with reset assertion.
  always_ff @(posedge clock) begin
    if (reset && proc_wren && !is_mmio) mem[proc_addr] <= proc_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      proc_rdata_q <= '0;
      vga_rdata_q  <= '0;
      in_s1_q      <= '0;
      in_s2_q      <= '0;
      vs_s1_q      <= 1'b0;
      vs_s2_q      <= 1'b0;
      vs_prev_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      proc_rdata_q <= proc_rdata_d;
      vga_rdata_q  <= mem[vga_addr];
      in_s1_q      <= in_raw;
      in_s2_q      <= in_s1_q;
      vs_s1_q      <= vsync;
      vs_s2_q      <= vs_s1_q;
      vs_prev_q    <= vs_s2_q;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign proc_rdata = proc_rdata_q;
  assign vga_rdata  = vga_rdata_q;

endmodule

`default_nettype wire
